// File: rtl/instruction_fetcher_pkg.sv
// instruction_fetcher_pkg: shared widths, JAL opcode, FIFO entry layout and J-immediate decode.
package instruction_fetcher_pkg;
    localparam int XLEN       = 32;
    localparam int INST_WIDTH = 32;
    localparam logic [6:0] OPCODE_JAL = 7'b1101111;

    typedef struct packed {
        logic [INST_WIDTH-1:0] inst;
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       pred;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    function automatic logic [XLEN-1:0] j_imm(input logic [INST_WIDTH-1:0] i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction
endpackage

// File: rtl/instruction_fetcher_fetch_queue.sv
// fetch_queue: power-of-two FIFO of fetched entries with flush; pointers wrap naturally,
// count is one bit wider so its MSB alone signals full.
module fetch_queue import instruction_fetcher_pkg::*; #(
    parameter int DEPTH = 16
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               i_en,
    input  logic               i_flush,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic [ENTRY_W-1:0] i_data,
    output logic [ENTRY_W-1:0] o_head,
    output logic               o_full,
    output logic               o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]      r_head;
    logic [AW-1:0]      r_tail;
    logic [AW:0]        r_count;
    logic               w_we;

    assign w_we    = rst_in & i_en & ~i_flush & i_push;
    assign o_head  = r_mem[r_head];
    assign o_full  = r_count[AW];
    assign o_empty = (r_count == '0);

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_en) begin
            if (i_flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (i_push) r_tail <= r_tail + AW'(1);
                if (i_pop) r_head <= r_head + AW'(1);
                r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_we) r_mem[r_tail] <= i_data;
    end
endmodule

// File: rtl/instruction_fetcher.sv
// instruction_fetcher: owns the PC, requests words from the cache and queues them for decode.
// Define FETCH_JAL_PREDICT_EN to follow JAL targets at fetch time with no bubble.
module instruction_fetcher import instruction_fetcher_pkg::*; #(
    parameter int              QUEUE_DEPTH = 16,
    parameter logic [XLEN-1:0] RESET_PC    = 32'h0
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  rob_clear,
    input  logic [XLEN-1:0]       rob_clear_pc,
    output logic                  inst_valid,
    output logic [XLEN-1:0]       pc_out,
    input  logic                  inst_ready,
    input  logic [INST_WIDTH-1:0] inst_res,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INST_WIDTH-1:0] out_inst,
    output logic [XLEN-1:0]       out_pc,
    output logic [XLEN-1:0]       out_pred_pc
);
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pred;
    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    fetch_entry_t    w_entry;
    fetch_entry_t    w_head;

    // Request depends only on registered count, so it cannot drop while a miss is pending.
    assign inst_valid  = rst_in & ~w_full;
    assign pc_out      = r_pc;
    assign out_valid   = ~w_empty;
    assign w_push      = rdy_in & inst_valid & inst_ready & ~rob_clear;
    assign w_pop       = rdy_in & out_valid & out_ready & ~rob_clear;
    assign w_entry     = '{inst: inst_res, pc: r_pc, pred: w_pred};
    assign out_inst    = w_head.inst;
    assign out_pc      = w_head.pc;
    assign out_pred_pc = w_head.pred;

    always_comb begin
`ifdef FETCH_JAL_PREDICT_EN
        w_pred = (inst_res[6:0] == OPCODE_JAL) ? r_pc + j_imm(inst_res) : r_pc + 32'd4;
`else
        w_pred = r_pc + 32'd4;
`endif
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) r_pc <= RESET_PC;
        else if (rdy_in & rob_clear) r_pc <= rob_clear_pc;
        else if (w_push) r_pc <= w_pred;
    end

    fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .i_en    (rdy_in),
        .i_flush (rob_clear),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_entry),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
endmodule

// File: tb/tb_instruction_fetcher.sv
// tb_instruction_fetcher: directed stimulus, queue-based reference model, per-cycle compare.
module tb_instruction_fetcher;
    logic        clk_in = 0;
    logic        rst_in, rdy_in, rob_clear, inst_ready, out_ready;
    logic [31:0] rob_clear_pc;
    logic        inst_valid, out_valid;
    logic [31:0] pc_out, inst_res, out_inst, out_pc, out_pred_pc;
    logic        jal_mode;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pred;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc;
    bit          m_ok = 0;

    instruction_fetcher dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .rob_clear   (rob_clear),
        .rob_clear_pc(rob_clear_pc),
        .inst_valid  (inst_valid),
        .pc_out      (pc_out),
        .inst_ready  (inst_ready),
        .inst_res    (inst_res),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .out_pred_pc (out_pred_pc)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[24:0], 7'b0010011};
    endfunction

    // jal ra, +0x20 placed at address 0x8 during the JAL phase
    assign inst_res = (jal_mode && pc_out == 32'h8) ? 32'h020000EF : word_at(pc_out);

    function automatic logic [31:0] pred_of(input logic [31:0] pc, input logic [31:0] inst);
`ifdef FETCH_JAL_PREDICT_EN
        if (inst[6:0] == 7'b1101111)
            return pc + {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
`endif
        return pc + 32'd4;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk_in) begin
        if (!rst_in) begin
            q.delete();
            m_pc = 32'h0;
            m_ok = 1;
        end else if (rdy_in) begin
            if (rob_clear) begin
                q.delete();
                m_pc = rob_clear_pc;
            end else begin
                automatic bit   do_pop  = (q.size() != 0) && out_ready;
                automatic bit   do_push = (q.size() < 16) && inst_ready;
                automatic ent_t e;
                e.inst = inst_res;
                e.pc   = m_pc;
                e.pred = pred_of(m_pc, inst_res);
                if (do_pop) void'(q.pop_front());
                if (do_push) begin
                    q.push_back(e);
                    m_pc = e.pred;
                end
            end
        end
    end

    always @(negedge clk_in) begin
        if (m_ok) begin
            chk("inst_valid", {31'b0, inst_valid}, {31'b0, rst_in && q.size() < 16});
            chk("pc_out", pc_out, m_pc);
            chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
            if (q.size() != 0) begin
                chk("out_inst", out_inst, q[0].inst);
                chk("out_pc", out_pc, q[0].pc);
                chk("out_pred_pc", out_pred_pc, q[0].pred);
            end
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    initial begin
        logic [31:0] cap_pc, cap_out;
        logic [31:0] jal_next;
`ifdef FETCH_JAL_PREDICT_EN
        jal_next = 32'h28;
`else
        jal_next = 32'hC;
`endif
        rst_in = 0; rdy_in = 1; rob_clear = 0; rob_clear_pc = 0;
        inst_ready = 0; out_ready = 0; jal_mode = 0;
        cyc(2);
        chk("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_pc_out", pc_out, 32'h0);
        rst_in = 1;

        inst_ready = 1; out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("stream_out_pc", out_pc, 32'(4 * i));
        end

        rst_in = 0; cyc(); rst_in = 1;
        out_ready = 0;
        cyc(20);
        chk("full_inst_valid", {31'b0, inst_valid}, 32'h0);
        chk("full_pc_out", pc_out, 32'h40);
        out_ready = 1;
        cyc();
        out_ready = 0;
        chk("after_pop_inst_valid", {31'b0, inst_valid}, 32'h1);
        chk("after_pop_pc_out", pc_out, 32'h40);
        chk("after_pop_head", out_pc, 32'h4);
        cyc();
        out_ready = 1; inst_ready = 0;
        cyc(20);
        chk("drained", {31'b0, out_valid}, 32'h0);

        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("miss_inst_valid", {31'b0, inst_valid}, 32'h1);
            chk("miss_pc_out", pc_out, 32'h44);
        end
        inst_ready = 1;
        cyc();
        inst_ready = 0;
        chk("miss_done_pc", pc_out, 32'h48);
        chk("miss_done_head", out_pc, 32'h44);

        inst_ready = 1; rob_clear = 1; rob_clear_pc = 32'h1000;
        cyc();
        rob_clear = 0; inst_ready = 0;
        chk("clr_out_valid", {31'b0, out_valid}, 32'h0);
        chk("clr_pc_out", pc_out, 32'h1000);
        chk("clr_inst_valid", {31'b0, inst_valid}, 32'h1);

        rst_in = 0; cyc(); rst_in = 1;
        jal_mode = 1; out_ready = 0; inst_ready = 1;
        cyc(3);
        inst_ready = 0;
        chk("jal_next_pc", pc_out, jal_next);
        out_ready = 1;
        cyc(2);
        out_ready = 0; jal_mode = 0;
        chk("jal_out_pc", out_pc, 32'h8);
        chk("jal_out_pred", out_pred_pc, jal_next);
        chk("jal_out_inst", out_inst, 32'h020000EF);

        inst_ready = 1; out_ready = 1;
        cyc(2);
        cap_pc = pc_out; cap_out = out_pc;
        rdy_in = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("frz_pc_out", pc_out, cap_pc);
            chk("frz_out_pc", out_pc, cap_out);
        end
        rdy_in = 1;
        cyc();
        chk("resume_pc_out", pc_out, cap_pc + 32'd4);
        cyc(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
